// File: rtl/hand_gesture_pkg.sv
// Shared definitions for the hand-gesture centroid path: frame geometry,
// coordinate widths and the mask-streamer scan states.
package hand_gesture_pkg;

    localparam int H_RES_DEF = 1280;
    localparam int V_RES_DEF = 720;
    localparam int X_W       = 11;
    localparam int Y_W       = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        TAB   = 2'd3
    } scan_state_t;

endpackage

// File: rtl/mask_pixel_streamer_coord_pipe.sv
// DEPTH-stage shift register that carries {in_frame, x, y} alongside the mask
// BRAM read so coordinates line up with the returned mask bit.
module coord_pipe #(
    parameter int DEPTH = 2,
    parameter int W     = 22
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic [W-1:0] d_in,
    output logic [W-1:0] q_out
);

    logic [W-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= d_in;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q_out = stage_q[DEPTH-1];

endmodule

// File: rtl/mask_pixel_streamer.sv
// Walks a 1-bit mask frame buffer in row-major order, emitting one (x, y) beat
// per set bit and closing each frame with a single tabulate pulse.
//
// state | meaning
// IDLE  | waiting for start_in; rd_addr_out held at 0
// SCAN  | issuing one read address per cycle, 0..N-1
// DRAIN | letting the last reads and their beats flush out (RD_LATENCY+1 cycles)
// TAB   | tabulate_out high for one cycle; pixel count latched
module mask_pixel_streamer
    import hand_gesture_pkg::*;
#(
    parameter int H_RES      = H_RES_DEF,
    parameter int V_RES      = V_RES_DEF,
    parameter int RD_LATENCY = 2,
    parameter int ADDR_W     = $clog2(H_RES*V_RES)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              start_in,
    output logic [ADDR_W-1:0] rd_addr_out,
    input  logic              rd_data_in,
    output logic [X_W-1:0]    x_out,
    output logic [Y_W-1:0]    y_out,
    output logic              valid_out,
    output logic              tabulate_out,
    output logic              busy_out,
    output logic [ADDR_W-1:0] pixel_count_out
);

    localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(H_RES*V_RES - 1);
    localparam logic [X_W-1:0]    X_LAST     = X_W'(H_RES - 1);
    localparam logic [2:0]        DRAIN_INIT = 3'(RD_LATENCY);
    localparam int                PW         = 1 + X_W + Y_W;

    scan_state_t       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [X_W-1:0]    xc_q, xc_d;
    logic [Y_W-1:0]    yc_q, yc_d;
    logic [2:0]        drain_q, drain_d;

    logic [X_W-1:0]    x_q;
    logic [Y_W-1:0]    y_q;
    logic              valid_q;
    logic [ADDR_W-1:0] run_cnt_q, run_cnt_d;
    logic [ADDR_W-1:0] pix_cnt_q;

    logic [PW-1:0]     pipe_in, pipe_out;
    logic              tail_in_frame, beat, start_ok;
    logic [X_W-1:0]    tail_x;
    logic [Y_W-1:0]    tail_y;

    assign pipe_in = {state_q == SCAN, xc_q, yc_q};

    coord_pipe #(
        .DEPTH (RD_LATENCY),
        .W     (PW)
    ) u_coord_pipe (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .d_in   (pipe_in),
        .q_out  (pipe_out)
    );

    assign {tail_in_frame, tail_x, tail_y} = pipe_out;
    assign beat     = tail_in_frame & rd_data_in;
    assign start_ok = (state_q == IDLE) & start_in;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        xc_d    = xc_q;
        yc_d    = yc_q;
        drain_d = drain_q;
        case (state_q)
            IDLE: begin
                if (start_in) begin
                    state_d = SCAN;
                    addr_d  = '0;
                    xc_d    = '0;
                    yc_d    = '0;
                end
            end
            SCAN: begin
                if (addr_q == ADDR_LAST) begin
                    state_d = DRAIN;
                    drain_d = DRAIN_INIT;
                    addr_d  = '0;
                    xc_d    = '0;
                    yc_d    = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                    if (xc_q == X_LAST) begin
                        xc_d = '0;
                        yc_d = yc_q + 1'b1;
                    end else begin
                        xc_d = xc_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (drain_q == '0) state_d = TAB;
                else               drain_d = drain_q - 1'b1;
            end
            TAB:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        run_cnt_d = run_cnt_q;
        if (start_ok)  run_cnt_d = '0;
        else if (beat) run_cnt_d = run_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            addr_q  <= '0;
            xc_q    <= '0;
            yc_q    <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            xc_q    <= xc_d;
            yc_q    <= yc_d;
            drain_q <= drain_d;
        end
    end

    // Coordinates only move on a beat so downstream sees the last pixel held.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            valid_q   <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            run_cnt_q <= '0;
            pix_cnt_q <= '0;
        end else begin
            valid_q   <= beat;
            run_cnt_q <= run_cnt_d;
            if (beat) begin
                x_q <= tail_x;
                y_q <= tail_y;
            end
            if (state_q == TAB) pix_cnt_q <= run_cnt_q;
        end
    end

    assign rd_addr_out     = addr_q;
    assign x_out           = x_q;
    assign y_out           = y_q;
    assign valid_out       = valid_q;
    assign tabulate_out    = (state_q == TAB);
    assign busy_out        = (state_q != IDLE);
    assign pixel_count_out = pix_cnt_q;

endmodule

// File: tb/tb_mask_pixel_streamer.sv
// Scoreboard bench for mask_pixel_streamer on an 8x4 frame with a 2-cycle
// BRAM model; expectations come from the frame contents and start cycle.
module tb_mask_pixel_streamer;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int L  = 2;
    localparam int N  = H * V;
    localparam int AW = 6;

    logic          clk_in   = 1'b0;
    logic          rst_in   = 1'b1;
    logic          start_in = 1'b0;
    logic          rd_data_in;
    logic [AW-1:0] rd_addr_out, pixel_count_out;
    logic [10:0]   x_out;
    logic [9:0]    y_out;
    logic          valid_out, tabulate_out, busy_out;

    mask_pixel_streamer #(
        .H_RES      (H),
        .V_RES      (V),
        .RD_LATENCY (L),
        .ADDR_W     (AW)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .start_in        (start_in),
        .rd_addr_out     (rd_addr_out),
        .rd_data_in      (rd_data_in),
        .x_out           (x_out),
        .y_out           (y_out),
        .valid_out       (valid_out),
        .tabulate_out    (tabulate_out),
        .busy_out        (busy_out),
        .pixel_count_out (pixel_count_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    bit mask [64];
    logic [L-1:0] bram_q = '0;
    always @(posedge clk_in) bram_q <= {bram_q[L-2:0], mask[rd_addr_out]};
    assign rd_data_in = bram_q[L-1];

    typedef struct { int x; int y; int t; } beat_t;
    typedef struct { int t; int cnt; } tab_t;
    beat_t exp_q [$];
    tab_t  tab_q [$];

    int checks = 0;
    int errors = 0;
    int win_t0 = -1000;
    int last_x = 0, last_y = 0;
    bit cnt_pending = 0;
    int cnt_exp = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: frame started (start sampled) at cycle t0 issues address n
    // at t0+n+1, emits its beat at t0+n+2+L, tabulates at t0+N+2+L.
    task automatic launch();
        int c;
        c = 0;
        win_t0 = cyc;
        for (int n = 0; n < N; n++) begin
            if (mask[n]) begin
                exp_q.push_back('{n % H, n / H, cyc + n + 2 + L});
                c++;
            end
        end
        tab_q.push_back('{cyc + N + 2 + L, c});
        start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
    endtask

    task automatic pulse_start();
        start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk_in);
    endtask

    task automatic set_mask(input int mode, input int k);
        for (int n = 0; n < 64; n++) begin
            case (mode)
                0:       mask[n] = 1'b0;
                1:       mask[n] = (n == 2*H + 5);
                2:       mask[n] = 1'b1;
                default: mask[n] = ($urandom_range(0, 3) < k);
            endcase
        end
    endtask

    initial begin
        beat_t b;
        tab_t  f;
        forever begin
            @(negedge clk_in);
            if (rst_in) begin
                check("busy", int'(busy_out),
                      int'(cyc >= win_t0 + 1 && cyc <= win_t0 + N + 2 + L));
                check("rd_addr", int'(rd_addr_out),
                      (cyc >= win_t0 + 1 && cyc <= win_t0 + N) ? cyc - win_t0 - 1 : 0);
                while (exp_q.size() > 0 && exp_q[0].t < cyc) begin
                    b = exp_q.pop_front();
                    check("missed_beat", cyc, b.t);
                end
                while (tab_q.size() > 0 && tab_q[0].t < cyc) begin
                    f = tab_q.pop_front();
                    check("missed_tab", cyc, f.t);
                end
                if (valid_out) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 1, 0);
                    end else begin
                        b = exp_q.pop_front();
                        check("beat_cycle", cyc, b.t);
                        check("beat_x", int'(x_out), b.x);
                        check("beat_y", int'(y_out), b.y);
                        last_x = b.x;
                        last_y = b.y;
                    end
                end else begin
                    check("hold_x", int'(x_out), last_x);
                    check("hold_y", int'(y_out), last_y);
                end
                if (cnt_pending) begin
                    check("pixel_count", int'(pixel_count_out), cnt_exp);
                    cnt_pending = 0;
                end
                if (tabulate_out) begin
                    check("tab_no_beat", int'(valid_out), 0);
                    if (tab_q.size() == 0) begin
                        check("unexpected_tab", 1, 0);
                    end else begin
                        f = tab_q.pop_front();
                        check("tab_cycle", cyc, f.t);
                        cnt_pending = 1;
                        cnt_exp = f.cnt;
                    end
                end
            end
        end
    end

    initial begin
        int t0;
        set_mask(0, 0);
        #1 rst_in = 1'b0;
        repeat (3) @(negedge clk_in);
        check("rst_valid", int'(valid_out), 0);
        check("rst_tab", int'(tabulate_out), 0);
        check("rst_busy", int'(busy_out), 0);
        check("rst_addr", int'(rd_addr_out), 0);
        check("rst_count", int'(pixel_count_out), 0);
        #2 rst_in = 1'b1;
        @(negedge clk_in);

        set_mask(0, 0);
        t0 = cyc; launch(); wait_until(t0 + N + L + 5);
        set_mask(1, 0);
        t0 = cyc; launch(); wait_until(t0 + N + L + 5);
        set_mask(2, 0);
        t0 = cyc; launch(); wait_until(t0 + N + L + 5);

        // Starts while busy (mid-scan and in the TAB cycle) must be ignored.
        set_mask(3, 2);
        t0 = cyc; launch();
        wait_until(t0 + 10);        pulse_start();
        wait_until(t0 + N + 2 + L); pulse_start();
        check("restart_cycle", cyc, t0 + N + 3 + L);
        t0 = cyc; launch(); wait_until(t0 + N + L + 5);

        // Reset mid-frame aborts with no tabulate; a fresh start scans cleanly.
        set_mask(1, 0);
        t0 = cyc; launch();
        wait_until(t0 + 15);
        #2 rst_in = 1'b0;
        #1;
        check("arst_valid", int'(valid_out), 0);
        check("arst_tab", int'(tabulate_out), 0);
        check("arst_busy", int'(busy_out), 0);
        check("arst_addr", int'(rd_addr_out), 0);
        check("arst_x", int'(x_out), 0);
        check("arst_y", int'(y_out), 0);
        check("arst_count", int'(pixel_count_out), 0);
        exp_q.delete();
        tab_q.delete();
        win_t0 = -1000;
        cnt_pending = 0;
        last_x = 0;
        last_y = 0;
        repeat (2) @(negedge clk_in);
        #2 rst_in = 1'b1;
        @(negedge clk_in);
        t0 = cyc; launch(); wait_until(t0 + N + L + 5);

        for (int i = 0; i < 6; i++) begin
            set_mask(3, (i % 4) + 1);
            t0 = cyc; launch(); wait_until(t0 + N + L + 5);
        end

        check("leftover_beats", exp_q.size(), 0);
        check("leftover_tabs", tab_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
